// File: rtl/zap_postalu_pkg.sv
// Shared types for the post-ALU register pipeline: control vector layout,
// control width and the two-state sleep machine encoding.
package zap_postalu_pkg;

  localparam int CTL_W = 10;

  // Per-instruction control bits, most significant first.
  typedef struct packed {
    logic dav;
    logic decompile_valid;
    logic uop_last;
    logic abt;
    logic irq;
    logic fiq;
    logic swi;
    logic und;
    logic wb_cyc;
    logic wb_stb;
  } ctl_t;

  typedef enum logic {
    RUN   = 1'b0,
    SLEEP = 1'b1
  } state_t;

endpackage

// File: rtl/zap_postalu_stage.sv
// One post-ALU register slot. Control always reloads when enabled; the wide
// payload reloads only when the incoming slot is valid, so idle slots do not
// toggle the datapath flops.
module zap_postalu_stage
  import zap_postalu_pkg::*;
#(
  parameter int PAYLOAD_W = 1024,
  parameter bit XPROP     = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_load_ctl,
  input  logic                 i_load_pay,
  input  logic                 i_kill,
  input  ctl_t                 i_ctl,
  input  logic [PAYLOAD_W-1:0] i_payload,
  output ctl_t                 o_ctl,
  output logic [PAYLOAD_W-1:0] o_payload
);

  // X makes stale data visible in simulation; zero keeps netlists X-free.
  localparam logic [PAYLOAD_W-1:0] KILL_PAY = XPROP ? {PAYLOAD_W{1'bx}} : {PAYLOAD_W{1'b0}};

  ctl_t                 ctl_reg;
  logic [PAYLOAD_W-1:0] payload_reg;

  // Slot register: reset/kill empties it, otherwise load on the enables.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_kill) begin
      ctl_reg     <= '0;
      payload_reg <= KILL_PAY;
    end else begin
      if (i_load_ctl) begin
        ctl_reg <= i_ctl;
      end
      if (i_load_pay) begin
        payload_reg <= i_payload;
      end
    end
  end

  assign o_ctl     = ctl_reg;
  assign o_payload = payload_reg;

endmodule

// File: rtl/zap_postalu_pipe.sv
// Multi-stage post-ALU register pipeline with a RUN/SLEEP fault machine,
// optional drain of in-flight instructions on a data abort, and occupancy
// and sleep status.
module zap_postalu_pipe
  import zap_postalu_pkg::*;
#(
  parameter int DEPTH          = 1,
  parameter int PAYLOAD_W      = 1024,
  parameter bit DRAIN_ON_FAULT = 1'b0,
  parameter bit XPROP          = 1'b1
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_clear_from_writeback,
  input  logic                         i_data_stall,
  input  logic                         i_data_mem_fault,
  input  ctl_t                         i_ctl,
  input  logic [PAYLOAD_W-1:0]         i_payload,
  output ctl_t                         o_ctl,
  output logic [PAYLOAD_W-1:0]         o_payload,
  output logic                         o_sleep,
  output logic [$clog2(DEPTH+1)-1:0]   o_occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  if ((DEPTH < 1) || (DEPTH > 8)) begin : g_bad_depth
    $fatal(1, "zap_postalu_pipe: DEPTH must be in 1..8");
  end

  state_t state_reg;
  logic   sleep_reg;
  logic   stall;
  logic   kill_new;

  ctl_t                 stage_ctl  [DEPTH];
  logic [PAYLOAD_W-1:0] stage_pay  [DEPTH];
  ctl_t                 feed_ctl   [DEPTH];
  logic [PAYLOAD_W-1:0] feed_pay   [DEPTH];
  logic                 stage_kill [DEPTH];
  logic [OCC_W-1:0]     occ_count;

  // Clear overrides a cache stall; a fault under stall is simply lost.
  assign stall    = i_data_stall & ~i_clear_from_writeback;
  assign kill_new = i_clear_from_writeback |
                    (~stall & ((state_reg == SLEEP) | i_data_mem_fault));

  // Fault machine: clear/reset return to RUN, an unstalled fault sleeps.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_reg <= RUN;
      sleep_reg <= 1'b0;
    end else if (i_clear_from_writeback) begin
      state_reg <= RUN;
      sleep_reg <= 1'b0;
    end else if (!i_data_stall && i_data_mem_fault) begin
      state_reg <= SLEEP;
      sleep_reg <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign feed_ctl[gi] = i_ctl;
      assign feed_pay[gi] = i_payload;
    end else begin : g_body
      assign feed_ctl[gi] = stage_ctl[gi-1];
      assign feed_pay[gi] = stage_pay[gi-1];
    end

    // In drain mode only the entry slot takes the fault bubble; older slots
    // keep shifting so in-flight work leaves the pipe. Clear hits all.
    assign stage_kill[gi] = ((gi == 0) || !DRAIN_ON_FAULT) ? kill_new
                                                           : i_clear_from_writeback;

    zap_postalu_stage #(
      .PAYLOAD_W (PAYLOAD_W),
      .XPROP     (XPROP)
    ) u_stage (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_load_ctl (~stall),
      .i_load_pay (~stall & feed_ctl[gi].dav),
      .i_kill     (stage_kill[gi]),
      .i_ctl      (feed_ctl[gi]),
      .i_payload  (feed_pay[gi]),
      .o_ctl      (stage_ctl[gi]),
      .o_payload  (stage_pay[gi])
    );
  end

  // Occupancy: popcount of the registered dav bits, so no input-to-output path.
  always_comb begin
    occ_count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_count = occ_count + OCC_W'(stage_ctl[k].dav);
    end
  end

  assign o_ctl       = stage_ctl[DEPTH-1];
  assign o_payload   = stage_pay[DEPTH-1];
  assign o_sleep     = sleep_reg;
  assign o_occupancy = occ_count;

endmodule

// File: tb/tb_zap_postalu_pipe.sv
// Directed bench for zap_postalu_pipe. Three instances share one stimulus:
//   a: DEPTH=3, kill-all on fault, XPROP=1
//   b: DEPTH=3, drain on fault,    XPROP=0
//   c: DEPTH=1, drain on fault,    XPROP=0 (must behave like kill-all)
module tb_zap_postalu_pipe;
  import zap_postalu_pkg::*;

  localparam int PW = 16;
  localparam logic [CTL_W-1:0] DAV_BITS = 10'h2A5;

  logic          clk = 1'b0;
  logic          rst_n, clr, stl, flt;
  ctl_t          in_ctl;
  logic [PW-1:0] in_pay;

  ctl_t          a_ctl, b_ctl, c_ctl;
  logic [PW-1:0] a_pay, b_pay, c_pay;
  logic          a_slp, b_slp, c_slp;
  logic [1:0]    a_occ, b_occ;
  logic [0:0]    c_occ;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  zap_postalu_pipe #(.DEPTH(3), .PAYLOAD_W(PW), .DRAIN_ON_FAULT(1'b0), .XPROP(1'b1)) dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_clear_from_writeback(clr), .i_data_stall(stl),
    .i_data_mem_fault(flt), .i_ctl(in_ctl), .i_payload(in_pay),
    .o_ctl(a_ctl), .o_payload(a_pay), .o_sleep(a_slp), .o_occupancy(a_occ));

  zap_postalu_pipe #(.DEPTH(3), .PAYLOAD_W(PW), .DRAIN_ON_FAULT(1'b1), .XPROP(1'b0)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_clear_from_writeback(clr), .i_data_stall(stl),
    .i_data_mem_fault(flt), .i_ctl(in_ctl), .i_payload(in_pay),
    .o_ctl(b_ctl), .o_payload(b_pay), .o_sleep(b_slp), .o_occupancy(b_occ));

  zap_postalu_pipe #(.DEPTH(1), .PAYLOAD_W(PW), .DRAIN_ON_FAULT(1'b1), .XPROP(1'b0)) dut_c (
    .i_clk(clk), .i_reset_n(rst_n), .i_clear_from_writeback(clr), .i_data_stall(stl),
    .i_data_mem_fault(flt), .i_ctl(in_ctl), .i_payload(in_pay),
    .o_ctl(c_ctl), .o_payload(c_pay), .o_sleep(c_slp), .o_occupancy(c_occ));

  typedef struct packed {
    logic          rst_n, clr, stl, flt, dav;
    logic [PW-1:0] pay;
    logic          a_dav;
    logic [PW-1:0] a_pay;
    logic [1:0]    a_occ;
    logic          a_slp;
    logic          b_dav;
    logic [PW-1:0] b_pay;
    logic [1:0]    b_occ;
    logic          b_slp;
    logic          c_dav;
    logic [PW-1:0] c_pay;
    logic          c_slp;
  } vec_t;

  localparam int NVEC = 27;
  vec_t tbl [NVEC];

  function automatic vec_t mk(
      input logic r, input logic c, input logic s, input logic f, input logic d,
      input logic [PW-1:0] p,
      input logic ad, input logic [PW-1:0] ap, input logic [1:0] ao, input logic asl,
      input logic bd, input logic [PW-1:0] bp, input logic [1:0] bo, input logic bsl,
      input logic cd, input logic [PW-1:0] cp, input logic csl);
    vec_t v;
    v.rst_n = r; v.clr = c; v.stl = s; v.flt = f; v.dav = d; v.pay = p;
    v.a_dav = ad; v.a_pay = ap; v.a_occ = ao; v.a_slp = asl;
    v.b_dav = bd; v.b_pay = bp; v.b_occ = bo; v.b_slp = bsl;
    v.c_dav = cd; v.c_pay = cp; v.c_slp = csl;
    return v;
  endfunction

  function automatic logic [CTL_W-1:0] exp_ctl(input logic dav);
    return dav ? DAV_BITS : '0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end else begin
      passes++;
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic s, input logic f,
                       input logic d, input logic [PW-1:0] p);
    rst_n  = r;
    clr    = c;
    stl    = s;
    flt    = f;
    in_ctl = d ? ctl_t'(DAV_BITS) : ctl_t'('0);
    in_pay = p;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    //            rst clr stl flt dav pay     | a: dav pay   occ slp | b: dav pay   occ slp | c: dav pay   slp
    tbl[0]  = mk(0, 0, 0, 0, 0, 16'h00,   0, 16'h00, 0, 0,   0, 16'h00, 0, 0,   0, 16'h00, 0);
    tbl[1]  = mk(1, 0, 0, 0, 1, 16'h0A,   0, 16'h00, 1, 0,   0, 16'h00, 1, 0,   1, 16'h0A, 0);
    tbl[2]  = mk(1, 0, 0, 0, 1, 16'h0B,   0, 16'h00, 2, 0,   0, 16'h00, 2, 0,   1, 16'h0B, 0);
    tbl[3]  = mk(1, 0, 0, 0, 1, 16'h0C,   1, 16'h0A, 3, 0,   1, 16'h0A, 3, 0,   1, 16'h0C, 0);
    tbl[4]  = mk(1, 0, 0, 0, 0, 16'h00,   1, 16'h0B, 2, 0,   1, 16'h0B, 2, 0,   0, 16'h0C, 0);
    tbl[5]  = mk(1, 0, 0, 0, 0, 16'h00,   1, 16'h0C, 1, 0,   1, 16'h0C, 1, 0,   0, 16'h0C, 0);
    tbl[6]  = mk(1, 0, 0, 0, 0, 16'h00,   0, 16'h00, 0, 0,   0, 16'h0C, 0, 0,   0, 16'h0C, 0);
    tbl[7]  = mk(1, 0, 0, 0, 1, 16'h1D,   0, 16'h00, 1, 0,   0, 16'h0C, 1, 0,   1, 16'h1D, 0);
    tbl[8]  = mk(1, 0, 0, 0, 1, 16'h1E,   0, 16'h00, 2, 0,   0, 16'h0C, 2, 0,   1, 16'h1E, 0);
    tbl[9]  = mk(1, 0, 1, 0, 1, 16'h1F,   0, 16'h00, 2, 0,   0, 16'h0C, 2, 0,   1, 16'h1E, 0);
    tbl[10] = mk(1, 0, 1, 0, 1, 16'h1F,   0, 16'h00, 2, 0,   0, 16'h0C, 2, 0,   1, 16'h1E, 0);
    tbl[11] = mk(1, 0, 1, 1, 1, 16'h1F,   0, 16'h00, 2, 0,   0, 16'h0C, 2, 0,   1, 16'h1E, 0);
    tbl[12] = mk(1, 0, 1, 0, 1, 16'h1F,   0, 16'h00, 2, 0,   0, 16'h0C, 2, 0,   1, 16'h1E, 0);
    tbl[13] = mk(1, 0, 0, 0, 0, 16'h00,   1, 16'h1D, 2, 0,   1, 16'h1D, 2, 0,   0, 16'h1E, 0);
    tbl[14] = mk(1, 0, 0, 0, 0, 16'h00,   1, 16'h1E, 1, 0,   1, 16'h1E, 1, 0,   0, 16'h1E, 0);
    tbl[15] = mk(1, 0, 0, 0, 0, 16'h00,   0, 16'h00, 0, 0,   0, 16'h1E, 0, 0,   0, 16'h1E, 0);
    tbl[16] = mk(1, 0, 0, 0, 1, 16'h21,   0, 16'h00, 1, 0,   0, 16'h1E, 1, 0,   1, 16'h21, 0);
    tbl[17] = mk(1, 0, 0, 0, 1, 16'h22,   0, 16'h00, 2, 0,   0, 16'h1E, 2, 0,   1, 16'h22, 0);
    tbl[18] = mk(1, 0, 0, 0, 1, 16'h23,   1, 16'h21, 3, 0,   1, 16'h21, 3, 0,   1, 16'h23, 0);
    tbl[19] = mk(1, 0, 0, 1, 1, 16'h24,   0, 16'h00, 0, 1,   1, 16'h22, 2, 1,   0, 16'h00, 1);
    tbl[20] = mk(1, 0, 0, 0, 1, 16'h25,   0, 16'h00, 0, 1,   1, 16'h23, 1, 1,   0, 16'h00, 1);
    tbl[21] = mk(1, 0, 0, 0, 1, 16'h26,   0, 16'h00, 0, 1,   0, 16'h23, 0, 1,   0, 16'h00, 1);
    tbl[22] = mk(1, 1, 0, 1, 0, 16'h00,   0, 16'h00, 0, 0,   0, 16'h00, 0, 0,   0, 16'h00, 0);
    tbl[23] = mk(1, 0, 0, 0, 1, 16'h27,   0, 16'h00, 1, 0,   0, 16'h00, 1, 0,   1, 16'h27, 0);
    tbl[24] = mk(1, 0, 0, 0, 1, 16'h28,   0, 16'h00, 2, 0,   0, 16'h00, 2, 0,   1, 16'h28, 0);
    tbl[25] = mk(0, 0, 0, 0, 1, 16'h29,   0, 16'h00, 0, 0,   0, 16'h00, 0, 0,   0, 16'h00, 0);
    tbl[26] = mk(1, 0, 0, 0, 0, 16'h00,   0, 16'h00, 0, 0,   0, 16'h00, 0, 0,   0, 16'h00, 0);

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].rst_n, tbl[i].clr, tbl[i].stl, tbl[i].flt, tbl[i].dav, tbl[i].pay);
      tick();
      $display("vec %0d: a_ctl=%h b_ctl=%h/%h c_ctl=%h/%h occ=%0d/%0d/%0d sleep=%b%b%b",
               i, a_ctl, b_ctl, b_pay, c_ctl, c_pay, a_occ, b_occ, c_occ, a_slp, b_slp, c_slp);
      chk($sformatf("v%0d a_ctl", i), 32'(a_ctl), 32'(exp_ctl(tbl[i].a_dav)));
      chk($sformatf("v%0d a_occ", i), 32'(a_occ), 32'(tbl[i].a_occ));
      chk($sformatf("v%0d a_sleep", i), 32'(a_slp), 32'(tbl[i].a_slp));
      if (tbl[i].a_dav) begin
        chk($sformatf("v%0d a_pay", i), 32'(a_pay), 32'(tbl[i].a_pay));
      end
      chk($sformatf("v%0d b_ctl", i), 32'(b_ctl), 32'(exp_ctl(tbl[i].b_dav)));
      chk($sformatf("v%0d b_pay", i), 32'(b_pay), 32'(tbl[i].b_pay));
      chk($sformatf("v%0d b_occ", i), 32'(b_occ), 32'(tbl[i].b_occ));
      chk($sformatf("v%0d b_sleep", i), 32'(b_slp), 32'(tbl[i].b_slp));
      chk($sformatf("v%0d c_ctl", i), 32'(c_ctl), 32'(exp_ctl(tbl[i].c_dav)));
      chk($sformatf("v%0d c_pay", i), 32'(c_pay), 32'(tbl[i].c_pay));
      chk($sformatf("v%0d c_occ", i), 32'(c_occ), 32'(tbl[i].c_dav));
      chk($sformatf("v%0d c_sleep", i), 32'(c_slp), 32'(tbl[i].c_slp));
    end

    // Stall while asleep, drain under stall, then clear with stall+fault.
    drive(1, 0, 0, 0, 1, 16'h31); tick();
    $display("seq load: a_occ=%0d b_occ=%0d", a_occ, b_occ);
    chk("seq load a_occ", 32'(a_occ), 32'd1);
    chk("seq load b_occ", 32'(b_occ), 32'd1);

    drive(1, 0, 0, 1, 0, 16'h00); tick();
    $display("seq fault: a_slp=%b b_slp=%b a_occ=%0d b_occ=%0d", a_slp, b_slp, a_occ, b_occ);
    chk("seq fault a_sleep", 32'(a_slp), 32'd1);
    chk("seq fault a_occ", 32'(a_occ), 32'd0);
    chk("seq fault b_sleep", 32'(b_slp), 32'd1);
    chk("seq fault b_occ", 32'(b_occ), 32'd1);

    drive(1, 0, 1, 0, 1, 16'h32); tick();
    $display("seq sleep stall: a_slp=%b b_occ=%0d b_ctl=%h", a_slp, b_occ, b_ctl);
    chk("seq sleep-stall a_sleep", 32'(a_slp), 32'd1);
    chk("seq sleep-stall b_occ", 32'(b_occ), 32'd1);
    chk("seq sleep-stall b_ctl", 32'(b_ctl), 32'd0);

    drive(1, 0, 0, 0, 1, 16'h33); tick();
    $display("seq drain: b_ctl=%h b_pay=%h a_occ=%0d", b_ctl, b_pay, a_occ);
    chk("seq drain b_ctl", 32'(b_ctl), 32'(DAV_BITS));
    chk("seq drain b_pay", 32'(b_pay), 32'h31);
    chk("seq drain a_occ", 32'(a_occ), 32'd0);
    chk("seq drain a_sleep", 32'(a_slp), 32'd1);

    drive(1, 1, 1, 1, 1, 16'h35); tick();
    $display("seq clear: sleep=%b%b%b occ=%0d/%0d/%0d", a_slp, b_slp, c_slp, a_occ, b_occ, c_occ);
    chk("seq clear a_sleep", 32'(a_slp), 32'd0);
    chk("seq clear b_sleep", 32'(b_slp), 32'd0);
    chk("seq clear c_sleep", 32'(c_slp), 32'd0);
    chk("seq clear a_occ", 32'(a_occ), 32'd0);
    chk("seq clear b_occ", 32'(b_occ), 32'd0);

    drive(1, 0, 0, 0, 1, 16'h34); tick();
    chk("seq restart a_occ", 32'(a_occ), 32'd1);
    drive(1, 0, 0, 0, 0, 16'h00); tick();
    drive(1, 0, 0, 0, 0, 16'h00); tick();
    $display("seq restart: a_ctl=%h a_pay=%h", a_ctl, a_pay);
    chk("seq restart a_ctl", 32'(a_ctl), 32'(DAV_BITS));
    chk("seq restart a_pay", 32'(a_pay), 32'h34);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
